// File: rtl/mem_access_stage.sv
// Memory-access stage: big-endian byte/halfword/word loads and stores with a one-cycle write-back strobe.
// Optional bus timeout is compiled in with `define MEM_ACCESS_TIMEOUT_EN.
module mem_access_stage #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_store_data,
    input  logic [4:0]        in_dest_reg,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_dest_reg,
    output logic [31:0]       wb_value,
    output logic              align_trap,
    output logic              bus_error
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    localparam logic [3:0] OP_PASS = 4'd0;
    localparam logic [3:0] OP_LDUB = 4'd2;
    localparam logic [3:0] OP_LDSB = 4'd3;
    localparam logic [3:0] OP_LDUH = 4'd4;
    localparam logic [3:0] OP_LDSH = 4'd5;
    localparam logic [3:0] OP_LD   = 4'd6;
    localparam logic [3:0] OP_STB  = 4'd7;
    localparam logic [3:0] OP_STH  = 4'd8;
    localparam logic [3:0] OP_ST   = 4'd9;

    logic [0:0]        state_reg;
    logic [3:0]        op_reg;
    logic [4:0]        dest_reg;
    logic [1:0]        off_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [3:0]        be_reg;
    logic [31:0]       wdata_reg;
    logic              wb_valid_reg;
    logic [4:0]        wb_rd_reg;
    logic [31:0]       wb_value_reg;
    logic              align_trap_reg;
    logic              timeout;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cycles
        // Parameter guard only; legal settings never elaborate this block.
    end

    // ---------------- input decode ----------------
    logic        in_is_mem;
    logic        in_is_store;
    logic        in_misaligned;
    logic [3:0]  in_be;
    logic [31:0] in_wdata;
    logic [3:0]  byte_onehot;

    // be[3] is byte offset 0 (most significant lane)
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_be
        assign byte_onehot[3-gi] = (in_addr[1:0] == 2'(gi));
    end

    always_comb begin
        in_is_mem     = (in_op >= OP_LDUB) && (in_op <= OP_ST);
        in_is_store   = (in_op >= OP_STB) && (in_op <= OP_ST);
        in_misaligned = 1'b0;
        in_be         = 4'b1111;
        in_wdata      = in_store_data;
        case (in_op)
            OP_LDUH, OP_LDSH: in_misaligned = in_addr[0];
            OP_LD:            in_misaligned = (in_addr[1:0] != 2'b00);
            OP_STB: begin
                in_be    = byte_onehot;
                in_wdata = {4{in_store_data[7:0]}};
            end
            OP_STH: begin
                in_misaligned = in_addr[0];
                in_be         = in_addr[1] ? 4'b0011 : 4'b1100;
                in_wdata      = {2{in_store_data[15:0]}};
            end
            OP_ST:            in_misaligned = (in_addr[1:0] != 2'b00);
            default: ;
        endcase
    end

    // ---------------- load extraction ----------------
    logic [7:0]  rd_lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_value;

    for (genvar gi = 0; gi < 4; gi++) begin : g_rd_lane
        assign rd_lane[gi] = dmem_rdata[31-8*gi -: 8];
    end

    always_comb begin
        byte_sel = rd_lane[off_reg];
        half_sel = off_reg[1] ? dmem_rdata[15:0] : dmem_rdata[31:16];
        case (op_reg)
            OP_LDUB: load_value = {24'd0, byte_sel};
            OP_LDSB: load_value = {{24{byte_sel[7]}}, byte_sel};
            OP_LDUH: load_value = {16'd0, half_sel};
            OP_LDSH: load_value = {{16{half_sel[15]}}, half_sel};
            default: load_value = dmem_rdata;
        endcase
    end

    // ---------------- main FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            op_reg         <= 4'd0;
            dest_reg       <= 5'd0;
            off_reg        <= 2'd0;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            be_reg         <= 4'd0;
            wdata_reg      <= 32'd0;
            wb_valid_reg   <= 1'b0;
            wb_rd_reg      <= 5'd0;
            wb_value_reg   <= 32'd0;
            align_trap_reg <= 1'b0;
        end else begin
            wb_valid_reg   <= 1'b0;
            align_trap_reg <= 1'b0;
            if (state_reg == IDLE) begin
                if (in_valid) begin
                    if (in_op == OP_PASS) begin
                        if (in_dest_reg != 5'd0) begin
                            wb_valid_reg <= 1'b1;
                            wb_rd_reg    <= in_dest_reg;
                            wb_value_reg <= 32'(in_addr);
                        end
                    end else if (in_is_mem) begin
                        if (in_misaligned) begin
                            align_trap_reg <= 1'b1;
                        end else begin
                            state_reg <= ACCESS;
                            op_reg    <= in_op;
                            dest_reg  <= in_dest_reg;
                            off_reg   <= in_addr[1:0];
                            we_reg    <= in_is_store;
                            addr_reg  <= {in_addr[ADDR_W-1:2], 2'b00};
                            be_reg    <= in_be;
                            wdata_reg <= in_wdata;
                        end
                    end
                end
            end else begin
                // An ack in the timeout cycle takes priority and completes normally
                if (dmem_ack) begin
                    state_reg <= IDLE;
                    if (!we_reg && dest_reg != 5'd0) begin
                        wb_valid_reg <= 1'b1;
                        wb_rd_reg    <= dest_reg;
                        wb_value_reg <= load_value;
                    end
                end else if (timeout) begin
                    state_reg <= IDLE;
                end
            end
        end
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             bus_error_reg;

    assign timeout = (state_reg == ACCESS) && !dmem_ack
                     && (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    // Held at zero in IDLE, so it starts from zero on every entry to ACCESS
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg       <= '0;
            bus_error_reg <= 1'b0;
        end else begin
            bus_error_reg <= timeout;
            if (state_reg == IDLE) begin
                cnt_reg <= '0;
            end else if (!dmem_ack) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign bus_error = bus_error_reg;
`else
    assign timeout   = 1'b0;
    assign bus_error = 1'b0;
`endif

    assign in_ready    = (state_reg == IDLE);
    assign dmem_req    = (state_reg == ACCESS);
    assign dmem_we     = we_reg;
    assign dmem_addr   = addr_reg;
    assign dmem_be     = be_reg;
    assign dmem_wdata  = wdata_reg;
    assign wb_valid    = wb_valid_reg;
    assign wb_dest_reg = wb_rd_reg;
    assign wb_value    = wb_value_reg;
    assign align_trap  = align_trap_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: PASS, loads/stores, lanes, traps, %g0, reset abort, timeout.
module tb_mem_access_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_addr;
    logic [31:0] in_store_data;
    logic [4:0]  in_dest_reg;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_dest_reg;
    logic [31:0] wb_value;
    logic        align_trap;
    logic        bus_error;

    int n_total;
    int n_bad;

    mem_access_stage #(
        .ADDR_W        (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_addr      (in_addr),
        .in_store_data(in_store_data),
        .in_dest_reg  (in_dest_reg),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
        .wb_valid     (wb_valid),
        .wb_dest_reg  (wb_dest_reg),
        .wb_value     (wb_value),
        .align_trap   (align_trap),
        .bus_error    (bus_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one memory op, hold the request wait_n extra cycles, then ack with rdata.
    task automatic access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                          input logic [4:0] dest, input logic [31:0] rdata, input int wait_n,
                          input logic [3:0] exp_be, input logic exp_we,
                          input logic chk_wd, input logic [31:0] exp_wd);
        $display("txn op=%0d addr=%h sd=%h dest=%0d rdata=%h wait=%0d", op, addr, sd, dest, rdata, wait_n);
        in_valid      = 1'b1;
        in_op         = op;
        in_addr       = addr;
        in_store_data = sd;
        in_dest_reg   = dest;
        tick();
        in_valid = 1'b0;
        in_op    = 4'd1;
        chk("req_rise", dmem_req, 1);
        chk("in_ready_busy", in_ready, 0);
        chk("we", dmem_we, exp_we);
        chk("be", dmem_be, exp_be);
        chk("addr", dmem_addr, addr & ~32'd3);
        if (chk_wd) chk("wdata", dmem_wdata, exp_wd);
        for (int i = 0; i < wait_n; i++) begin
            tick();
            chk("req_hold", dmem_req, 1);
            chk("be_hold", dmem_be, exp_be);
            chk("wb_early", wb_valid, 0);
            chk("bus_err_wait", bus_error, 0);
        end
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0BAD_F00D;
        chk("req_drop", dmem_req, 0);
        chk("in_ready_back", in_ready, 1);
        chk("bus_err_ack", bus_error, 0);
    endtask

    task automatic load_check(input string tag, input logic [3:0] op, input logic [31:0] addr,
                              input logic [4:0] dest, input logic [31:0] rdata,
                              input logic [31:0] exp_val);
        access(op, addr, 32'h0, dest, rdata, 0, 4'b1111, 1'b0, 1'b0, 32'h0);
        chk({tag, "_wb_valid"}, wb_valid, 1);
        chk({tag, "_value"}, wb_value, exp_val);
        chk({tag, "_dest"}, wb_dest_reg, dest);
        tick();
        chk({tag, "_wb_once"}, wb_valid, 0);
    endtask

    initial begin
        n_total       = 0;
        n_bad         = 0;
        reset         = 1'b0;
        in_valid      = 1'b0;
        in_op         = 4'd1;
        in_addr       = 32'h0;
        in_store_data = 32'h0;
        in_dest_reg   = 5'd0;
        dmem_ack      = 1'b0;
        dmem_rdata    = 32'h0;

        // Reset state
        #3;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_req", dmem_req, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_value", wb_value, 0);
        chk("rst_be", dmem_be, 0);
        chk("rst_align", align_trap, 0);
        chk("rst_bus_err", bus_error, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        tick();

        // Back-to-back PASS
        $display("txn PASS x3 addr=100 dest=5");
        in_valid    = 1'b1;
        in_op       = 4'd0;
        in_addr     = 32'd100;
        in_dest_reg = 5'd5;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pass_wb_valid", wb_valid, 1);
            chk("pass_value", wb_value, 32'd100);
            chk("pass_dest", wb_dest_reg, 5);
            chk("pass_in_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        in_op    = 4'd1;
        tick();
        chk("pass_wb_drop", wb_valid, 0);

        // Store with 3-cycle request, then load back
        access(4'd9, 32'h40, 32'hDEADBEEF, 5'd1, 32'h0, 2, 4'b1111, 1'b1, 1'b1, 32'hDEADBEEF);
        chk("st_no_wb", wb_valid, 0);
        tick();
        chk("st_no_wb2", wb_valid, 0);
        load_check("ld", 4'd6, 32'h40, 5'd7, 32'hDEADBEEF, 32'hDEADBEEF);

        // Lane extraction and extension
        load_check("ldsb", 4'd3, 32'h43, 5'd3, 32'h123456F0, 32'hFFFFFFF0);
        load_check("lduh", 4'd4, 32'h42, 5'd4, 32'h123456F0, 32'h000056F0);
        load_check("ldub", 4'd2, 32'h40, 5'd8, 32'h123456F0, 32'h00000012);
        load_check("ldsh", 4'd5, 32'h40, 5'd9, 32'h80017F00, 32'hFFFF8001);
        load_check("ldsb1", 4'd3, 32'h41, 5'd10, 32'h12A456F0, 32'hFFFFFFA4);

        // Sub-word stores
        access(4'd7, 32'h41, 32'h000000AB, 5'd0, 32'h0, 0, 4'b0100, 1'b1, 1'b1, 32'hABABABAB);
        chk("stb_no_wb", wb_valid, 0);
        access(4'd8, 32'h42, 32'h1234CAFE, 5'd0, 32'h0, 1, 4'b0011, 1'b1, 1'b1, 32'hCAFECAFE);
        chk("sth_no_wb", wb_valid, 0);
        access(4'd7, 32'h43, 32'h00000055, 5'd0, 32'h0, 0, 4'b0001, 1'b1, 1'b1, 32'h55555555);
        tick();

        // Misaligned word load and halfword store
        $display("txn LD misaligned addr=0x42");
        in_valid    = 1'b1;
        in_op       = 4'd6;
        in_addr     = 32'h42;
        in_dest_reg = 5'd7;
        tick();
        in_valid = 1'b0;
        in_op    = 4'd1;
        chk("mis_trap", align_trap, 1);
        chk("mis_no_req", dmem_req, 0);
        chk("mis_no_wb", wb_valid, 0);
        chk("mis_in_ready", in_ready, 1);
        tick();
        chk("mis_trap_once", align_trap, 0);
        chk("mis_no_req2", dmem_req, 0);
        $display("txn STH misaligned addr=0x41");
        in_valid = 1'b1;
        in_op    = 4'd8;
        in_addr  = 32'h41;
        tick();
        in_valid = 1'b0;
        in_op    = 4'd1;
        chk("sth_mis_trap", align_trap, 1);
        chk("sth_mis_no_req", dmem_req, 0);
        tick();

        // %g0 destination suppresses write-back
        access(4'd6, 32'h44, 32'h0, 5'd0, 32'h11223344, 0, 4'b1111, 1'b0, 1'b0, 32'h0);
        chk("g0_ld_no_wb", wb_valid, 0);
        $display("txn PASS dest=0");
        in_valid    = 1'b1;
        in_op       = 4'd0;
        in_addr     = 32'd77;
        in_dest_reg = 5'd0;
        tick();
        chk("g0_pass_no_wb", wb_valid, 0);

        // NOP, unknown op, and a stray ack in IDLE
        $display("txn NOP / op 15 / stray ack");
        in_op       = 4'd1;
        in_dest_reg = 5'd6;
        tick();
        chk("nop_no_wb", wb_valid, 0);
        chk("nop_no_req", dmem_req, 0);
        in_op = 4'd15;
        tick();
        chk("op15_no_wb", wb_valid, 0);
        chk("op15_no_req", dmem_req, 0);
        in_valid   = 1'b0;
        in_op      = 4'd1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hFFFFFFFF;
        tick();
        dmem_ack = 1'b0;
        chk("idle_ack_no_wb", wb_valid, 0);
        chk("idle_ack_ready", in_ready, 1);

        // Reset during ACCESS, late ack afterwards
        $display("txn LD dest=9 aborted by reset");
        in_valid    = 1'b1;
        in_op       = 4'd6;
        in_addr     = 32'h80;
        in_dest_reg = 5'd9;
        tick();
        in_valid = 1'b0;
        in_op    = 4'd1;
        chk("abort_req_up", dmem_req, 1);
        #2 reset = 1'b0;
        #1;
        chk("abort_req_drop", dmem_req, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_addr_clr", dmem_addr, 0);
        chk("abort_be_clr", dmem_be, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h12345678;
        tick();
        dmem_ack = 1'b0;
        chk("late_ack_no_wb", wb_valid, 0);
        chk("late_ack_no_req", dmem_req, 0);
        tick();
        chk("late_ack_no_wb2", wb_valid, 0);

`ifdef MEM_ACCESS_TIMEOUT_EN
        // Timeout after 4 request cycles without ack
        $display("txn LD no ack, timeout");
        in_valid    = 1'b1;
        in_op       = 4'd6;
        in_addr     = 32'h84;
        in_dest_reg = 5'd6;
        tick();
        in_valid = 1'b0;
        in_op    = 4'd1;
        for (int i = 0; i < 4; i++) begin
            chk("to_req_held", dmem_req, 1);
            chk("to_no_err_yet", bus_error, 0);
            tick();
        end
        chk("to_req_drop", dmem_req, 0);
        chk("to_bus_error", bus_error, 1);
        chk("to_in_ready", in_ready, 1);
        chk("to_no_wb", wb_valid, 0);
        tick();
        chk("to_bus_error_once", bus_error, 0);
`else
        // Without the timeout a slow ack is simply waited for
        access(4'd6, 32'h84, 32'h0, 5'd6, 32'hCAFEF00D, 6, 4'b1111, 1'b0, 1'b0, 32'h0);
        chk("slow_wb_valid", wb_valid, 1);
        chk("slow_value", wb_value, 32'hCAFEF00D);
        chk("slow_no_bus_err", bus_error, 0);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage of the SPARC pipeline; sits between execute and write-back.
- Accepts one instruction per handshake from execute, performs the big-endian byte, halfword or word load/store on the data-memory port, and forms the load value.
- Produces the write-back pair (wb_dest_reg, wb_value) with a one-cycle wb_valid strobe; write-back writes the register file from that pair.
- Non-memory results pass through with one cycle of latency.

Parameters:
- ADDR_W, 32, data-memory address width.
- TIMEOUT_CYCLES, 16, maximum cycles dmem_req is held waiting for dmem_ack. Used only with the optional feature.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  execute has an instruction
- in_ready  out  1  stage can accept; high only in IDLE
- in_op  in  4  0 PASS, 1 NOP, 2 LDUB, 3 LDSB, 4 LDUH, 5 LDSH, 6 LD, 7 STB, 8 STH, 9 ST; other codes act as NOP
- in_addr  in  ADDR_W  effective address, or ALU result for PASS
- in_store_data  in  32  store source (rd)
- in_dest_reg  in  5  destination register
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = store
- dmem_addr  out  ADDR_W  word-aligned address (low 2 bits forced to 0)
- dmem_be  out  4  byte enables; be[3] = byte 0 (MSB lane)
- dmem_wdata  out  32  store data, replicated into the lanes
- dmem_ack  in  1  memory completion; read data valid in the same cycle
- dmem_rdata  in  32  read data
- wb_valid  out  1  one-cycle strobe to write-back
- wb_dest_reg  out  5  register to write
- wb_value  out  32  value to write
- align_trap  out  1  one-cycle misalignment strobe
- bus_error  out  1  one-cycle timeout strobe; tied 0 when the feature is absent

Behaviour:
- Reset (reset = 0, asynchronous):
  - FSM goes to IDLE.
  - All outputs are 0, except in_ready = 1.
  - An in-flight access is abandoned; dmem_req drops immediately.
- FSM states: IDLE, ACCESS.
- Accept rule: the stage accepts when in_valid & in_ready are both high at a rising edge.
- IDLE, accept of PASS:
  - Next cycle wb_valid = 1, wb_value = in_addr, wb_dest_reg = in_dest_reg.
  - Stays in IDLE, so back-to-back PASS runs at 1 per cycle.
- IDLE, accept of NOP: no output.
- Misalignment check on accept:
  - Halfword ops (LDUH, LDSH, STH) with addr[0] = 1, or word ops (LD, ST) with addr[1:0] != 0, are misaligned.
  - Result: align_trap = 1 for one cycle, no memory request, no wb_valid, stays in IDLE.
- IDLE, accept of an aligned memory op:
  - Registers dmem_addr, dmem_we, dmem_be, dmem_wdata, the op and the destination; goes to ACCESS.
  - dmem_req = 1 from the next cycle.
- ACCESS:
  - dmem_req and all dmem_* outputs are held stable until dmem_ack is sampled high; in_ready = 0.
  - On the ack edge the state returns to IDLE. dmem_req is low and in_ready high in the following cycle.
  - For loads, wb_valid = 1 in the cycle after the ack, carrying the extracted value.
  - Stores produce no wb_valid.
  - Minimum load latency from accept edge to wb_valid is 2 cycles (ack in the first request cycle).
- Byte lanes (big-endian): offset k = addr[1:0]; byte lane k = bits [31-8k:24-8k]; halfword lane h = addr[1] (0 = bits [31:16]).
  - STB: be = one-hot at lane k; wdata = {4{rd[7:0]}}.
  - STH: be = 4'b1100 or 4'b0011; wdata = {2{rd[15:0]}}.
  - ST: be = 4'b1111.
  - Loads: be = 4'b1111; the byte or halfword is extracted from its lane, then zero-extended (LDUB/LDUH) or sign-extended (LDSB/LDSH).
- %g0: if the destination is 0, wb_valid is suppressed for PASS and for loads. The memory access still completes.
- dmem_ack is ignored while in IDLE, including a late ack after reset.
- in_op, in_addr, in_store_data and in_dest_reg are don't-care when in_valid = 0.

Optional Feature:
- Macro: MEM_ACCESS_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each cycle without ack.
  - When the count reaches TIMEOUT_CYCLES with no ack: dmem_req drops, the state returns to IDLE, bus_error = 1 for one cycle, and wb_valid stays low.
  - An ack arriving in the same cycle as the timeout wins: normal completion, no bus_error.
- Undefined: no counter; ACCESS waits indefinitely; bus_error is constant 0.

Test Plan:
- PASS, addr = 32'd100, dest = 5 on three consecutive cycles -> wb_valid high three consecutive cycles, each wb_value = 100, dest 5; in_ready stays 1.
- ST 32'hDEADBEEF @ 0x40, ack after 3 cycles; then LD @ 0x40 with dmem_rdata = 32'hDEADBEEF, dest 7, ack immediate:
  - Store: be = 1111, req held 3 cycles, no wb_valid.
  - Load: wb_valid 2 cycles after accept, value 32'hDEADBEEF.
- LDSB @ 0x43 with rdata 32'h123456F0, dest 3 -> wb_value = 32'hFFFFFFF0.
- LDUH @ 0x42 with the same rdata -> wb_value = 32'h000056F0.
- STB rd = 32'h000000AB @ 0x41 -> be = 0100, wdata = 32'hABABABAB.
- LD @ 0x42 -> align_trap single pulse, dmem_req never rises.
- LD to dest 0 -> access occurs, no wb_valid.
- Reset low during ACCESS, ack arriving after reset release -> outputs cleared immediately, ack ignored, no wb_valid.
- With MEM_ACCESS_TIMEOUT_EN, TIMEOUT_CYCLES = 4, no ack -> dmem_req high 4 cycles, then one-cycle bus_error, in_ready = 1.
